// File: rtl/clause_pkg.sv
`default_nettype none
// ============================================================================
// Module   : clause_pkg
// Brief    : Shared clause widths, clause type and dispatcher state encoding.
// Revision : 1.0
// ============================================================================
package clause_pkg;

  localparam int VARIABLE_LENGTH = 11;
  localparam int CLA_LENGTH      = 3;
  localparam int CLAUSE_W        = VARIABLE_LENGTH * CLA_LENGTH;

  typedef logic [CLAUSE_W-1:0] clause_t;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } disp_state_e;

endpackage
`default_nettype wire

// File: rtl/clause_fifo.sv
`default_nettype none
// ============================================================================
// Module   : clause_fifo
// Brief    : Per-engine clause FIFO, power-of-two depth, wrap-bit pointers.
// Revision : 1.0
// ============================================================================
module clause_fifo #(
  parameter int FIFO_DEPTH = 4,
  parameter int WIDTH      = 33
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_flush,
  input  logic             i_push,
  input  logic [WIDTH-1:0] i_data,
  input  logic             i_pop,
  output logic [WIDTH-1:0] o_data,
  output logic             o_full,
  output logic             o_empty
);

  localparam int c_AW = $clog2(FIFO_DEPTH);

  logic [WIDTH-1:0] r_mem [FIFO_DEPTH];
  logic [c_AW:0]    r_wr_ptr;
  logic [c_AW:0]    r_rd_ptr;
  logic             w_do_push;
  logic             w_do_pop;

  assign o_empty   = (r_wr_ptr == r_rd_ptr);
  assign o_full    = (r_wr_ptr[c_AW] != r_rd_ptr[c_AW]) &&
                     (r_wr_ptr[c_AW-1:0] == r_rd_ptr[c_AW-1:0]);
  assign o_data    = r_mem[r_rd_ptr[c_AW-1:0]];
  assign w_do_push = i_push && !o_full && !i_flush;
  assign w_do_pop  = i_pop && !o_empty;

  // Flush wins over any push/pop in the same cycle.
  always_ff @(posedge clk) begin
    if (rst || i_flush) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
    end else begin
      if (w_do_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_do_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (w_do_push) r_mem[r_wr_ptr[c_AW-1:0]] <= i_data;
  end

endmodule
`default_nettype wire

// File: rtl/clause_dispatcher.sv
`default_nettype none
// ============================================================================
// Module   : clause_dispatcher
// Brief    : Round-robin spread of released clauses into per-engine FIFOs,
//            unit-clause broadcast and end-of-pass detection.
//            Optional macro DISPATCH_STATS_EN adds dispatch/stall counters.
// Revision : 1.0
// ============================================================================
module clause_dispatcher #(
  parameter int NUM_ENGINE      = 4,
  parameter int CLA_LENGTH      = 3,
  parameter int VARIABLE_LENGTH = 11,
  parameter int FIFO_DEPTH      = 4
) (
  input  logic                                                 clock,
  input  logic                                                 reset,
  input  logic                                                 start_in,
  input  logic                                                 empty_in,
  input  logic [$clog2(NUM_ENGINE):0]                          clause_released_in,
  input  logic [NUM_ENGINE-1:0][VARIABLE_LENGTH*CLA_LENGTH-1:0] clause_in,
  input  logic [VARIABLE_LENGTH-1:0]                           chosen_uc_in,
  input  logic                                                 chosen_uc_valid_in,
  output logic [$clog2(NUM_ENGINE):0]                          clause_received_out,
  output logic [NUM_ENGINE-1:0][VARIABLE_LENGTH*CLA_LENGTH-1:0] eng_clause_out,
  output logic [NUM_ENGINE-1:0]                                eng_valid_out,
  input  logic [NUM_ENGINE-1:0]                                eng_ready_in,
  input  logic [NUM_ENGINE-1:0]                                eng_busy_in,
  output logic [VARIABLE_LENGTH-1:0]                           eng_uc_out,
  output logic                                                 eng_uc_valid_out,
`ifdef DISPATCH_STATS_EN
  output logic [NUM_ENGINE-1:0][31:0]                          stat_dispatched_out,
  output logic [31:0]                                          stat_stall_out,
`endif
  output logic                                                 done_out
);

  import clause_pkg::disp_state_e;
  import clause_pkg::IDLE;
  import clause_pkg::RUN;
  import clause_pkg::DRAIN;
  import clause_pkg::DONE;

  localparam int c_CLAUSE_W = VARIABLE_LENGTH * CLA_LENGTH;
  localparam int c_CNT_W    = $clog2(NUM_ENGINE) + 1;
  localparam int c_PTR_W    = (NUM_ENGINE > 1) ? $clog2(NUM_ENGINE) : 1;

  disp_state_e                          r_state;
  logic [c_PTR_W-1:0]                   r_rr_ptr;
  logic                                 r_done;
  logic                                 r_uc_valid;
  logic [VARIABLE_LENGTH-1:0]           r_uc;

  logic [c_CNT_W-1:0]                   w_released;
  logic [c_CNT_W-1:0]                   w_k;
  logic [c_PTR_W-1:0]                   w_tgt;
  logic                                 w_blocked;
  logic [NUM_ENGINE-1:0]                w_push;
  logic [NUM_ENGINE-1:0]                w_pop;
  logic [NUM_ENGINE-1:0]                w_full;
  logic [NUM_ENGINE-1:0]                w_empty;
  logic [NUM_ENGINE-1:0][c_CLAUSE_W-1:0] w_push_data;
  logic                                 w_flush;
  logic                                 w_drained;

  assign w_released = (clause_released_in > c_CNT_W'(NUM_ENGINE)) ?
                      c_CNT_W'(NUM_ENGINE) : clause_released_in;

  // Accept the longest prefix whose targets have room by registered occupancy.
  always_comb begin
    w_k         = '0;
    w_push      = '0;
    w_push_data = '0;
    w_blocked   = 1'b0;
    w_tgt       = '0;
    if (r_state == RUN) begin
      for (int i = 0; i < NUM_ENGINE; i++) begin
        w_tgt = c_PTR_W'((int'(r_rr_ptr) + i) % NUM_ENGINE);
        if (!w_blocked && (i < int'(w_released)) && !w_full[w_tgt]) begin
          w_push[w_tgt]      = 1'b1;
          w_push_data[w_tgt] = clause_in[i];
          w_k                = w_k + c_CNT_W'(1);
        end else begin
          w_blocked = 1'b1;
        end
      end
    end
  end

  assign w_flush   = ((r_state == RUN) || (r_state == DRAIN)) && !start_in;
  assign w_pop     = ~w_empty & eng_ready_in;
  assign w_drained = (&w_empty) && (eng_busy_in == '0);

  for (genvar e = 0; e < NUM_ENGINE; e++) begin : g_eng
    clause_fifo #(
      .FIFO_DEPTH (FIFO_DEPTH),
      .WIDTH      (c_CLAUSE_W)
    ) u_fifo (
      .clk     (clock),
      .rst     (reset),
      .i_flush (w_flush),
      .i_push  (w_push[e]),
      .i_data  (w_push_data[e]),
      .i_pop   (w_pop[e]),
      .o_data  (eng_clause_out[e]),
      .o_full  (w_full[e]),
      .o_empty (w_empty[e])
    );
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      r_state    <= IDLE;
      r_rr_ptr   <= '0;
      r_done     <= 1'b0;
      r_uc_valid <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (start_in) begin
            r_state    <= RUN;
            r_uc_valid <= 1'b1;
          end
        end
        RUN: begin
          if (!start_in) begin
            r_state    <= IDLE;
            r_rr_ptr   <= '0;
            r_uc_valid <= 1'b0;
          end else begin
            r_rr_ptr <= c_PTR_W'((int'(r_rr_ptr) + int'(w_k)) % NUM_ENGINE);
            if (empty_in && (clause_released_in == '0)) r_state <= DRAIN;
          end
        end
        DRAIN: begin
          if (!start_in) begin
            r_state    <= IDLE;
            r_rr_ptr   <= '0;
            r_uc_valid <= 1'b0;
          end else if (w_drained) begin
            r_state    <= DONE;
            r_done     <= 1'b1;
            r_uc_valid <= 1'b0;
          end
        end
        DONE: begin
          if (!start_in) begin
            r_state <= IDLE;
            r_done  <= 1'b0;
          end
        end
        default: begin
          r_state    <= IDLE;
          r_done     <= 1'b0;
          r_uc_valid <= 1'b0;
        end
      endcase
    end
  end

  // Capture is state-independent so a unit clause chosen in IDLE survives.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_uc <= '0;
    end else if (chosen_uc_valid_in) begin
      r_uc <= chosen_uc_in;
    end
  end

  assign clause_received_out = w_k;
  assign eng_valid_out       = ~w_empty;
  assign eng_uc_out          = r_uc;
  assign eng_uc_valid_out    = r_uc_valid;
  assign done_out            = r_done;

`ifdef DISPATCH_STATS_EN
  logic [NUM_ENGINE-1:0][31:0] r_stat_disp;
  logic [31:0]                 r_stat_stall;

  always_ff @(posedge clock) begin
    if (reset || ((r_state == IDLE) && start_in)) begin
      r_stat_disp  <= '0;
      r_stat_stall <= '0;
    end else begin
      for (int e = 0; e < NUM_ENGINE; e++) begin
        if (w_push[e] && !w_flush && (r_stat_disp[e] != '1))
          r_stat_disp[e] <= r_stat_disp[e] + 32'd1;
      end
      if ((r_state == RUN) && (w_k < w_released) && (r_stat_stall != '1))
        r_stat_stall <= r_stat_stall + 32'd1;
    end
  end

  assign stat_dispatched_out = r_stat_disp;
  assign stat_stall_out      = r_stat_stall;
`endif

endmodule
`default_nettype wire

// File: tb/tb_clause_dispatcher.sv
`default_nettype none
// ============================================================================
// Module   : tb_clause_dispatcher
// Brief    : Directed scoreboard bench for clause_dispatcher.
// Revision : 1.0
// ============================================================================
module tb_clause_dispatcher;

  localparam int NE = 4;
  localparam int CW = 33;
  localparam int VL = 11;

  logic                   clock = 1'b0;
  logic                   reset = 1'b1;
  logic                   start_in = 1'b0;
  logic                   empty_in = 1'b0;
  logic [2:0]             clause_released_in = '0;
  logic [NE-1:0][CW-1:0]  clause_in = '0;
  logic [VL-1:0]          chosen_uc_in = '0;
  logic                   chosen_uc_valid_in = 1'b0;
  logic [2:0]             clause_received_out;
  logic [NE-1:0][CW-1:0]  eng_clause_out;
  logic [NE-1:0]          eng_valid_out;
  logic [NE-1:0]          eng_ready_in = '0;
  logic [NE-1:0]          eng_busy_in = '0;
  logic [VL-1:0]          eng_uc_out;
  logic                   eng_uc_valid_out;
  logic                   done_out;
`ifdef DISPATCH_STATS_EN
  logic [NE-1:0][31:0]    stat_dispatched_out;
  logic [31:0]            stat_stall_out;
`endif

  logic [CW-1:0] exp_q [NE][$];
  int n_checks = 0;
  int n_fail   = 0;

  clause_dispatcher #(
    .NUM_ENGINE(NE), .CLA_LENGTH(3), .VARIABLE_LENGTH(VL), .FIFO_DEPTH(4)
  ) dut (
    .clock               (clock),
    .reset               (reset),
    .start_in            (start_in),
    .empty_in            (empty_in),
    .clause_released_in  (clause_released_in),
    .clause_in           (clause_in),
    .chosen_uc_in        (chosen_uc_in),
    .chosen_uc_valid_in  (chosen_uc_valid_in),
    .clause_received_out (clause_received_out),
    .eng_clause_out      (eng_clause_out),
    .eng_valid_out       (eng_valid_out),
    .eng_ready_in        (eng_ready_in),
    .eng_busy_in         (eng_busy_in),
    .eng_uc_out          (eng_uc_out),
    .eng_uc_valid_out    (eng_uc_valid_out),
`ifdef DISPATCH_STATS_EN
    .stat_dispatched_out (stat_dispatched_out),
    .stat_stall_out      (stat_stall_out),
`endif
    .done_out            (done_out)
  );

  always #5 clock = ~clock;

  function automatic logic [CW-1:0] mk(input int id);
    logic [10:0] v;
    v = 11'(id);
    return {v, ~v, v ^ 11'h2AA};
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic offer(input int n, input int base);
    clause_released_in = 3'(n);
    for (int i = 0; i < NE; i++) clause_in[i] = mk(base + i);
  endtask

  task automatic expect_push(input int e, input int id);
    exp_q[e].push_back(mk(id));
  endtask

  task automatic chk_rcv(input string name, input int exp);
    #1;
    chk(name, 64'(clause_received_out), 64'(exp));
  endtask

  // Scoreboard monitor: every head handed to an engine must be the next expected one.
  always @(negedge clock) begin
    logic [CW-1:0] x;
    if (!reset) begin
      for (int e = 0; e < NE; e++) begin
        if (eng_valid_out[e] && eng_ready_in[e]) begin
          if (exp_q[e].size() == 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL pop_e%0d: got %0h expected no clause", e, eng_clause_out[e]);
          end else begin
            x = exp_q[e].pop_front();
            chk($sformatf("head_e%0d", e), 64'(eng_clause_out[e]), 64'(x));
          end
        end
      end
    end
  end

  initial begin
    step(); step();
    reset = 1'b0;
    chk("rst_valid",    64'(eng_valid_out), 64'd0);
    chk("rst_done",     64'(done_out), 64'd0);
    chk("rst_uc_valid", 64'(eng_uc_valid_out), 64'd0);
    chk("rst_uc",       64'(eng_uc_out), 64'd0);
    chk_rcv("rst_rcv", 0);

    // Unit clause captured in IDLE, not yet flagged valid.
    chosen_uc_in = 11'h123; chosen_uc_valid_in = 1'b1;
    step();
    chosen_uc_valid_in = 1'b0;
    chk("idle_uc", 64'(eng_uc_out), 64'h123);
    chk("idle_uc_valid", 64'(eng_uc_valid_out), 64'd0);
    start_in = 1'b1; offer(4, 200);
    chk_rcv("idle_rcv", 0);
    step();
    chk("run_uc_valid", 64'(eng_uc_valid_out), 64'd1);
    chk("run_uc_kept", 64'(eng_uc_out), 64'h123);

    offer(4, 1);
    chk_rcv("rcv_abcd", 4);
    for (int e = 0; e < NE; e++) expect_push(e, 1 + e);
    step();
    offer(0, 0);
    chk("valid_abcd", 64'(eng_valid_out), 64'hF);
    chosen_uc_in = 11'h05A; chosen_uc_valid_in = 1'b1;
    eng_ready_in = 4'hF;
    step();
    chosen_uc_valid_in = 1'b0; eng_ready_in = 4'h0;
    chk("uc_05a", 64'(eng_uc_out), 64'h05A);
    chk("uc_valid", 64'(eng_uc_valid_out), 64'd1);
    chk("valid_after_pop", 64'(eng_valid_out), 64'd0);

    offer(7, 20);
    chk_rcv("rcv_clamp", 4);
    for (int e = 0; e < NE; e++) expect_push(e, 20 + e);
    step();
    offer(0, 0); eng_ready_in = 4'hF;
    chk("valid_clamp", 64'(eng_valid_out), 64'hF);
    step();
    eng_ready_in = 4'h0;

    offer(3, 30);
    chk_rcv("rcv_efg", 3);
    expect_push(0, 30); expect_push(1, 31); expect_push(2, 32);
    step();
    offer(3, 40);
    chk_rcv("rcv_hij", 3);
    expect_push(3, 40); expect_push(0, 41); expect_push(1, 42);
    step();
    chk("valid_rr", 64'(eng_valid_out), 64'hF);
    offer(4, 50);
    chk_rcv("rcv_klmn", 4);
    expect_push(2, 50); expect_push(3, 51); expect_push(0, 52); expect_push(1, 53);
    step();
    offer(2, 60);
    chk_rcv("rcv_op", 2);
    expect_push(2, 60); expect_push(3, 61);
    step();
    offer(4, 70);
    chk_rcv("rcv_qrst", 4);
    for (int e = 0; e < NE; e++) expect_push(e, 70 + e);
    step();

    // All full: a same-cycle pop must not free space.
    eng_ready_in = 4'b0001; offer(4, 80);
    chk_rcv("rcv_full_pop", 0);
    step();
    eng_ready_in = 4'b0000; offer(4, 90);
    chk_rcv("rcv_e1_full", 1);
    expect_push(0, 90);
    step();
    eng_ready_in = 4'b0010; offer(4, 100);
    chk_rcv("rcv_full_pop2", 0);
    step();
    eng_ready_in = 4'b0000; offer(4, 110);
    chk_rcv("rcv_rr1", 1);
    expect_push(1, 110);
    step();
    offer(0, 0); eng_ready_in = 4'hF;
    repeat (5) step();
    eng_ready_in = 4'h0;
    chk("valid_drained", 64'(eng_valid_out), 64'd0);

    offer(2, 120);
    chk_rcv("rcv_two", 2);
    expect_push(2, 120); expect_push(3, 121);
    step();
    offer(0, 0); empty_in = 1'b1;
    chk("valid_two", 64'(eng_valid_out), 64'b1100);
    step();
    chk("drain_uc_valid", 64'(eng_uc_valid_out), 64'd1);
    chk("drain_done0", 64'(done_out), 64'd0);
    eng_ready_in = 4'hF; eng_busy_in = 4'b0100;
    step();
    eng_ready_in = 4'h0;
    chk("drain_empty", 64'(eng_valid_out), 64'd0);
    chk("drain_done1", 64'(done_out), 64'd0);
    step();
    chk("busy_blocks_done", 64'(done_out), 64'd0);
    eng_busy_in = 4'b0000;
    step();
    chk("done_set", 64'(done_out), 64'd1);
    chk("done_uc_valid", 64'(eng_uc_valid_out), 64'd0);
    step();
    chk("done_hold", 64'(done_out), 64'd1);
    start_in = 1'b0; empty_in = 1'b0;
    step();
    chk("done_clear", 64'(done_out), 64'd0);
    offer(4, 0);
    chk_rcv("rcv_idle2", 0);
    offer(0, 0);

    // Abort mid-RUN with occupied FIFOs.
    start_in = 1'b1;
    step();
    offer(2, 130);
    chk_rcv("rcv_preflush", 2);
    step();
    offer(0, 0);
    chk("valid_preflush", 64'(eng_valid_out), 64'b0011);
    start_in = 1'b0;
    step();
    chk("flush_valid", 64'(eng_valid_out), 64'd0);
    chk("flush_done", 64'(done_out), 64'd0);
    chk("flush_uc_valid", 64'(eng_uc_valid_out), 64'd0);
    offer(4, 0);
    chk_rcv("flush_rcv", 0);
    offer(0, 0);
    start_in = 1'b1;
    step();
    offer(1, 140);
    chk_rcv("rcv_after_flush", 1);
    expect_push(0, 140);
    step();
    offer(0, 0);
    chk("rr_reset", 64'(eng_valid_out), 64'b0001);
    eng_ready_in = 4'hF;
    step();
    eng_ready_in = 4'h0;
    step();

    for (int e = 0; e < NE; e++)
      chk($sformatf("sb_left_e%0d", e), 64'(exp_q[e].size()), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/clause_dispatcher.md
Name: clause_dispatcher

Overview:
- Stage directly downstream of the latency buffer. Each cycle it takes up to NUM_ENGINE released clauses and spreads them round-robin into per-engine clause FIFOs.
- Returns the accepted count on the same cycle so the buffer can advance its head.
- Rebroadcasts the chosen unit clause to every BCP engine.
- Detects end-of-pass (buffer empty, all queues drained, all engines idle) and raises done.

Parameters:
- NUM_ENGINE, 4, number of BCP engines and maximum clauses offered per cycle.
- CLA_LENGTH, 3, literals per clause.
- VARIABLE_LENGTH, 11, bits per literal (clog2(LIT_IDX_MAX)+1, LIT_IDX_MAX=1024).
- FIFO_DEPTH, 4, entries per engine clause FIFO; must be a power of two, at least 2.

Ports:
- clock  in  1  system clock
- reset  in  1  synchronous, active-high reset
- start_in  in  1  level; pass active (the buffer's start_out)
- empty_in  in  1  buffer has no clauses left
- clause_released_in  in  clog2(NUM_ENGINE)+1  number of valid entries in clause_in, packed from index 0
- clause_in  in  NUM_ENGINE x VARIABLE_LENGTH*CLA_LENGTH  offered clauses
- chosen_uc_in  in  VARIABLE_LENGTH  chosen unit clause
- chosen_uc_valid_in  in  1  chosen_uc_in is valid
- clause_received_out  out  clog2(NUM_ENGINE)+1  clauses accepted this cycle (combinational)
- eng_clause_out  out  NUM_ENGINE x VARIABLE_LENGTH*CLA_LENGTH  per-engine FIFO head
- eng_valid_out  out  NUM_ENGINE  per-engine FIFO non-empty
- eng_ready_in  in  NUM_ENGINE  engine accepts its head this cycle
- eng_busy_in  in  NUM_ENGINE  engine still propagating
- eng_uc_out  out  VARIABLE_LENGTH  registered unit clause broadcast
- eng_uc_valid_out  out  1  eng_uc_out valid
- done_out  out  1  pass complete

Behaviour:
- Clock and reset: one clock, `clock`. Reset `reset` is synchronous and active-high.
- Reset values: state=IDLE, rr_ptr=0, all FIFOs empty, eng_valid_out=0, eng_uc_out=0, eng_uc_valid_out=0, done_out=0. clause_received_out is 0 because state is IDLE.
- FSM states: IDLE, RUN, DRAIN, DONE.
  - IDLE -> RUN when start_in=1.
  - RUN -> DRAIN when empty_in=1 and clause_released_in=0.
  - DRAIN -> DONE when all FIFOs are empty and eng_busy_in is all zero.
  - DONE holds done_out=1 and returns to IDLE when start_in=0.
  - In RUN or DRAIN, start_in=0 flushes all FIFOs, sets rr_ptr=0 and returns to IDLE next cycle. No done is raised.
- Dispatch (RUN only):
  - Offered clause i (i < clause_released_in) targets engine (rr_ptr+i) mod NUM_ENGINE.
  - k is the longest prefix i=0..k-1 whose target FIFOs are not full, using registered occupancy. A same-cycle pop does not free space; there is no pass-through.
  - clause_received_out=k, combinationally in the same cycle. The accepted clauses are written on the next edge.
  - rr_ptr <= (rr_ptr+k) mod NUM_ENGINE.
  - In every other state clause_received_out=0.
  - clause_released_in > NUM_ENGINE is clamped to NUM_ENGINE.
- FIFO pop: occurs when eng_valid_out[e] and eng_ready_in[e] are both 1. A pop and a push on the same FIFO in the same cycle are both legal. Pointers wrap modulo FIFO_DEPTH, with an extra wrap bit to tell full from empty.
- Unit clause broadcast:
  - chosen_uc_valid_in=1 captures chosen_uc_in; eng_uc_out updates the next cycle.
  - eng_uc_valid_out=1 in RUN and DRAIN, 0 otherwise.
  - A capture while in IDLE is kept and driven once RUN is entered.
- Latency:
  - Clause offered in cycle t (and accepted) appears on eng_clause_out from cycle t+1 at the earliest.
  - done_out asserts 1 cycle after the DRAIN exit condition is met.

Optional Feature:
- Macro: DISPATCH_STATS_EN.
- When defined, adds two outputs:
  - stat_dispatched_out: NUM_ENGINE x 32, clauses pushed per engine.
  - stat_stall_out: 32, cycles in RUN with k < clause_released_in.
- Both counters clear on reset and when entering RUN from IDLE, and saturate at all-ones.
- When not defined: these ports and counters are absent and the remaining behaviour is identical.

Decomposition:
- Shared package clause_pkg holds:
  - constants VARIABLE_LENGTH, CLA_LENGTH, CLAUSE_W = VARIABLE_LENGTH*CLA_LENGTH;
  - typedef clause_t (logic [CLAUSE_W-1:0]);
  - enum disp_state_e {IDLE, RUN, DRAIN, DONE}.
- One sub-module, clause_fifo: parameterised by FIFO_DEPTH, with push, pop, full and empty. It is instantiated NUM_ENGINE times via generate.

Test Plan:
- Reset then start_in=1, clause_released_in=4, clauses A,B,C,D, all FIFOs empty -> clause_received_out=4; next cycle engines 0..3 show A..D with eng_valid_out=4'b1111; rr_ptr=0.
- rr_ptr=0, clause_released_in=3 then 3 -> first cycle engines 0,1,2 are loaded; second cycle engines 3,0,1 are loaded; rr_ptr=2.
- FIFO of engine 1 full, eng_ready_in=0, rr_ptr=0, 4 offered -> clause_received_out=1 (only engine 0 loaded); rr_ptr=1.
- chosen_uc_valid_in=1 with chosen_uc_in=11'h05A in RUN -> eng_uc_out=11'h05A next cycle; eng_uc_valid_out=1.
- empty_in=1, clause_released_in=0, FIFOs hold 2 clauses, eng_busy_in=0 -> DRAIN; after both pops done_out=1 the following cycle; start_in=0 -> IDLE and done_out=0.
- start_in dropped mid-RUN with FIFOs non-empty -> next cycle eng_valid_out=0, clause_received_out=0, done_out=0, rr_ptr=0.
